// File: rtl/progmem_shared.sv
// Shared instruction memory: one single-port array serving several core fetch
// ports through a round-robin arbiter, with a registered one-cycle read path
// and a loader write port that takes priority over fetches.
module progmem_shared #(
  parameter int NUM_CORES = 4,
  parameter int INST_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ld_we,
  input  logic [ADDR_W-1:0]           ld_addr,
  input  logic [INST_W-1:0]           ld_data,
  input  logic [NUM_CORES-1:0]        req,
  input  logic [NUM_CORES*ADDR_W-1:0] addr,
  output logic [NUM_CORES-1:0]        gnt,
  output logic [NUM_CORES-1:0]        rvalid,
  output logic [INST_W-1:0]           rdata
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so that DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  logic [INST_W-1:0]    mem [DEPTH];
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     ptr_next;
  logic [NUM_CORES-1:0] gnt_vec;
  logic                 any_gnt;
  logic [ADDR_W-1:0]    sel_addr;
  logic                 sel_in_range;
  logic                 ld_in_range;

  // Round-robin search from rr_ptr; the loader and reset both suppress grants.
  always_comb begin : arbiter
    logic [PTR_W-1:0] cand;
    cand     = '0;
    gnt_vec  = '0;
    any_gnt  = 1'b0;
    ptr_next = rr_ptr;
    sel_addr = '0;
    if (!rst && !ld_we) begin
      for (int k = 0; k < NUM_CORES; k++) begin
        cand = PTR_W'((int'(rr_ptr) + k) % NUM_CORES);
        if (!any_gnt && req[cand]) begin
          any_gnt       = 1'b1;
          gnt_vec[cand] = 1'b1;
          sel_addr      = addr[cand*ADDR_W +: ADDR_W];
          ptr_next      = PTR_W'((int'(cand) + 1) % NUM_CORES);
        end
      end
    end
  end

  // Out-of-range addresses read as zero and are never written.
  always_comb begin
    sel_in_range = ({1'b0, sel_addr} < DEPTH_LIM);
    ld_in_range  = ({1'b0, ld_addr} < DEPTH_LIM);
  end

  assign gnt = gnt_vec;

  // Loader writes; the array itself is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (ld_we && ld_in_range) begin
      mem[ld_addr[IDX_W-1:0]] <= ld_data;
    end
  end

  // Registered read port, read-valid flags and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      rvalid <= '0;
      rdata  <= '0;
    end else if (any_gnt) begin
      rr_ptr <= ptr_next;
      rvalid <= gnt_vec;
      rdata  <= sel_in_range ? mem[sel_addr[IDX_W-1:0]] : '0;
    end else begin
      rvalid <= '0;
    end
  end

endmodule

// File: tb/tb_progmem_shared.sv
// Directed bench for progmem_shared: loader writes, single and multi-core
// fetches, round-robin order, loader priority, out-of-range handling and
// reset in the middle of a read.
module tb_progmem_shared;

  localparam int NUM_CORES = 4;
  localparam int INST_W    = 32;
  localparam int ADDR_W    = 8;
  localparam int DEPTH     = 64;

  logic                        clk;
  logic                        rst;
  logic                        ld_we;
  logic [ADDR_W-1:0]           ld_addr;
  logic [INST_W-1:0]           ld_data;
  logic [NUM_CORES-1:0]        req;
  logic [NUM_CORES*ADDR_W-1:0] addr;
  logic [NUM_CORES-1:0]        gnt;
  logic [NUM_CORES-1:0]        rvalid;
  logic [INST_W-1:0]           rdata;

  int checks = 0;
  int errors = 0;

  progmem_shared #(
    .NUM_CORES(NUM_CORES),
    .INST_W   (INST_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ld_we  (ld_we),
    .ld_addr(ld_addr),
    .ld_data(ld_data),
    .req    (req),
    .addr   (addr),
    .gnt    (gnt),
    .rvalid (rvalid),
    .rdata  (rdata)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_addr(input int core, input logic [ADDR_W-1:0] a);
    addr[core*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic apply_stimulus(input logic we, input logic [ADDR_W-1:0] la,
                                input logic [INST_W-1:0] ld, input logic [NUM_CORES-1:0] r);
    ld_we   = we;
    ld_addr = la;
    ld_data = ld;
    req     = r;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Directed sequence with hand-computed expectations.
  initial begin : stimulus
    logic [INST_W-1:0]    exp_word [4];
    logic [NUM_CORES-1:0] one_hot;
    exp_word[0] = 32'h11;
    exp_word[1] = 32'h22;
    exp_word[2] = 32'h33;
    exp_word[3] = 32'h44;

    // Reset with all cores requesting: no grant may leak out.
    rst  = 1'b1;
    addr = '0;
    apply_stimulus(1'b0, '0, '0, 4'b1111);
    tick();
    tick();
    check_output("reset_gnt", 32'(gnt), 32'h0);
    check_output("reset_rvalid", 32'(rvalid), 32'h0);
    check_output("reset_rdata", rdata, 32'h0);
    apply_stimulus(1'b0, '0, '0, 4'b0000);
    rst = 1'b0;
    tick();

    // Test 1: preload mem[0..3], then core0 fetches address 2.
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, ADDR_W'(i), exp_word[i], 4'b0000);
      tick();
    end
    apply_stimulus(1'b0, '0, '0, 4'b0001);
    set_addr(0, 8'd2);
    settle();
    check_output("t1_gnt", 32'(gnt), 32'h1);
    tick();
    check_output("t1_rvalid", 32'(rvalid), 32'h1);
    check_output("t1_rdata", rdata, 32'h33);
    req = 4'b0000;
    tick();
    check_output("t1_idle_rvalid", 32'(rvalid), 32'h0);
    check_output("t1_hold_rdata", rdata, 32'h33);

    // Test 2: fresh pointer, all four cores request addresses 0..3.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_addr(i, ADDR_W'(i));
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      one_hot = 4'b0001 << i;
      settle();
      check_output($sformatf("t2_gnt%0d", i), 32'(gnt), 32'(one_hot));
      tick();
      check_output($sformatf("t2_rvalid%0d", i), 32'(rvalid), 32'(one_hot));
      check_output($sformatf("t2_rdata%0d", i), rdata, exp_word[i]);
      req[i] = 1'b0;
    end
    tick();

    // Test 3: cores 1 and 3 request continuously; pointer starts at 0.
    req = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      one_hot = (i % 2 == 0) ? 4'b0010 : 4'b1000;
      settle();
      check_output($sformatf("t3_gnt%0d", i), 32'(gnt), 32'(one_hot));
      tick();
      check_output($sformatf("t3_rvalid%0d", i), 32'(rvalid), 32'(one_hot));
      check_output($sformatf("t3_rdata%0d", i), rdata, (i % 2 == 0) ? 32'h22 : 32'h44);
    end
    req = 4'b0000;
    tick();

    // Test 4: loader write blocks core2's fetch of the same address for one cycle.
    set_addr(2, 8'd5);
    apply_stimulus(1'b1, 8'd5, 32'hDEAD, 4'b0100);
    settle();
    check_output("t4_gnt_blocked", 32'(gnt), 32'h0);
    tick();
    ld_we = 1'b0;
    settle();
    check_output("t4_no_rvalid", 32'(rvalid), 32'h0);
    check_output("t4_gnt", 32'(gnt), 32'h4);
    tick();
    check_output("t4_rvalid", 32'(rvalid), 32'h4);
    check_output("t4_rdata", rdata, 32'hDEAD);
    req = 4'b0000;

    // Test 5: out-of-range fetch reads zero; out-of-range write must not alias mem[0].
    set_addr(0, 8'(DEPTH));
    req = 4'b0001;
    settle();
    check_output("t5_gnt_oor", 32'(gnt), 32'h1);
    tick();
    check_output("t5_rvalid_oor", 32'(rvalid), 32'h1);
    check_output("t5_rdata_oor", rdata, 32'h0);
    apply_stimulus(1'b1, 8'(DEPTH), 32'hCAFEBABE, 4'b0000);
    tick();
    ld_we = 1'b0;
    set_addr(0, 8'd0);
    req = 4'b0001;
    tick();
    check_output("t5_rvalid_mem0", 32'(rvalid), 32'h1);
    check_output("t5_rdata_mem0", rdata, 32'h11);
    req = 4'b0000;

    // Test 6: reset lands in the cycle after a grant to core1.
    set_addr(1, 8'd1);
    req = 4'b0010;
    settle();
    check_output("t6_gnt", 32'(gnt), 32'h2);
    tick();
    check_output("t6_rvalid_pre", 32'(rvalid), 32'h2);
    rst = 1'b1;
    req = 4'b0000;
    settle();
    check_output("t6_rvalid_rst", 32'(rvalid), 32'h0);
    check_output("t6_rdata_rst", rdata, 32'h0);
    tick();
    rst = 1'b0;
    exp_word[2] = 32'hDEAD;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      one_hot = 4'b0001 << i;
      settle();
      check_output($sformatf("t6_gnt%0d", i), 32'(gnt), 32'(one_hot));
      tick();
      check_output($sformatf("t6_rdata%0d", i), rdata, exp_word[i]);
      req[i] = 1'b0;
    end
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
